// File: rtl/varredura_destino.sv
// Raster-scan controller feeding the nearest-neighbour scaler and writing the framebuffer.
// Optional build macro VARREDURA_BORDA_EN: scan the whole framebuffer, zero-filling the border.
module varredura_destino #(
  parameter int unsigned LARGURA_ORIG = 320,
  parameter int unsigned ALTURA_ORIG  = 240,
  parameter int unsigned LARGURA_FB   = 640,
  parameter int unsigned ALTURA_FB    = 480,
  parameter int unsigned LAT_ROM      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  escala,
  input  logic [7:0]  pixel_in,
  input  logic        fb_ready,
  output logic [9:0]  x_dest,
  output logic [9:0]  y_dest,
  output logic        enable,
  output logic [18:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  output logic        busy,
  output logic        done,
  output logic        erro
);

  typedef enum logic [2:0] {StIdle, StEmite, StEspera, StEscreve, StFim} estado_t;

  estado_t     estado;
  logic [3:0]  cnt;
  logic [9:0]  w_q, h_q;
  logic [18:0] base_linha;

  logic [12:0] prod_w, prod_h, win_w, win_h;
  logic [9:0]  x_last, y_last, nx, ny;
  logic        fim_linha, fim_quadro, prox_borda;

  // Window size computed from the raw escala so it can be latched on the accepting edge.
  always_comb begin
    prod_w = 13'(LARGURA_ORIG) * 13'(escala);
    prod_h = 13'(ALTURA_ORIG) * 13'(escala);
    win_w  = (prod_w > 13'(LARGURA_FB)) ? 13'(LARGURA_FB) : prod_w;
    win_h  = (prod_h > 13'(ALTURA_FB)) ? 13'(ALTURA_FB) : prod_h;
  end

`ifdef VARREDURA_BORDA_EN
  assign x_last     = 10'(LARGURA_FB - 1);
  assign y_last     = 10'(ALTURA_FB - 1);
  assign prox_borda = !((nx < w_q) && (ny < h_q));
`else
  assign x_last     = w_q - 10'd1;
  assign y_last     = h_q - 10'd1;
  assign prox_borda = 1'b0;
`endif

  always_comb begin
    fim_linha  = (x_dest == x_last);
    fim_quadro = fim_linha && (y_dest == y_last);
    nx         = fim_linha ? 10'd0 : x_dest + 10'd1;
    ny         = fim_linha ? y_dest + 10'd1 : y_dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= StIdle;
      cnt        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      base_linha <= '0;
      x_dest     <= '0;
      y_dest     <= '0;
      enable     <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      fb_we      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      erro       <= 1'b0;
    end else begin
      enable <= 1'b0;
      done   <= 1'b0;
      erro   <= 1'b0;
      unique case (estado)
        // FIM already has busy low, so a start arriving there is accepted like in IDLE.
        StIdle, StFim: begin
          estado <= StIdle;
          if (start) begin
            if (escala == 3'd0) begin
              erro <= 1'b1;
            end else begin
              w_q        <= 10'(win_w);
              h_q        <= 10'(win_h);
              x_dest     <= '0;
              y_dest     <= '0;
              fb_addr    <= '0;
              base_linha <= '0;
              busy       <= 1'b1;
              enable     <= 1'b1;
              estado     <= StEmite;
            end
          end
        end
        StEmite: begin
          cnt    <= '0;
          estado <= StEspera;
        end
        StEspera: begin
          if (cnt == 4'(LAT_ROM - 1)) begin
            fb_data <= pixel_in;
            fb_we   <= 1'b1;
            estado  <= StEscreve;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        StEscreve: begin
          if (fb_ready) begin
            if (fim_quadro) begin
              fb_we  <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              estado <= StFim;
            end else begin
              x_dest <= nx;
              y_dest <= ny;
              if (fim_linha) begin
                base_linha <= base_linha + 19'(LARGURA_FB);
                fb_addr    <= base_linha + 19'(LARGURA_FB);
              end else begin
                fb_addr <= fb_addr + 19'd1;
              end
              // Border pixels bypass the scaler and are written straight away as zero.
              if (prox_borda) begin
                fb_data <= 8'h00;
                fb_we   <= 1'b1;
                estado  <= StEscreve;
              end else begin
                fb_we  <= 1'b0;
                enable <= 1'b1;
                estado <= StEmite;
              end
            end
          end
        end
        default: estado <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_varredura_destino.sv
// Self-checking bench for varredura_destino: scaler stub, write scoreboard, directed steps.
// Uses a reduced geometry (6x4 source, 16x10 framebuffer) to keep frames short.
module tb_varredura_destino;

  localparam int unsigned LO  = 6;
  localparam int unsigned AO  = 4;
  localparam int unsigned LFB = 16;
  localparam int unsigned AFB = 10;
  localparam int unsigned LAT = 2;
  localparam int          P   = LAT + 2;

  logic        clk = 1'b0;
  logic        rst, start, fb_ready;
  logic [2:0]  escala;
  logic [7:0]  pixel_in;
  logic [9:0]  x_dest, y_dest;
  logic        enable, fb_we, busy, done, erro;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;

  varredura_destino #(
    .LARGURA_ORIG (LO),
    .ALTURA_ORIG  (AO),
    .LARGURA_FB   (LFB),
    .ALTURA_FB    (AFB),
    .LAT_ROM      (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .escala   (escala),
    .pixel_in (pixel_in),
    .fb_ready (fb_ready),
    .x_dest   (x_dest),
    .y_dest   (y_dest),
    .enable   (enable),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_we    (fb_we),
    .busy     (busy),
    .done     (done),
    .erro     (erro)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pix(input logic [9:0] x, input logic [9:0] y);
    return {x[3:0], y[3:0]};
  endfunction

  // Scaler stub: returns pix(x,y) exactly LAT cycles after the enable cycle, 8'hFF otherwise.
  logic [7:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= enable ? pix(x_dest, y_dest) : 8'hFF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign pixel_in = pipe[LAT-1];

  // Framebuffer ready: optional 5-cycle stall on address 2, random while no write is pending.
  bit stall_on = 1'b0;
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (fb_we) begin
      fb_ready = !(stall_on && fb_addr == 19'd2 && stall_left > 0);
      if (!fb_ready) stall_left--;
    end else begin
      fb_ready = 1'($urandom_range(0, 1));
    end
  end

  logic [26:0] exp_q[$];
  logic [26:0] e;
  int          n_wr = 0, n_en = 0, n_done = 0, n_erro = 0;
  logic [18:0] last_addr = '0;
  int          w_cur = 1, h_cur = 1;
  int          we2_cycles = 0, hs2_cyc = -1, en_after = -1;
  logic [7:0]  we2_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (fb_we && fb_ready) begin
        n_wr++;
        last_addr = fb_addr;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL sb_underflow: write to %0d observed, no write expected", fb_addr);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(fb_addr), 32'(e[26:8]));
          chk("wr_data", 32'(fb_data), 32'(e[7:0]));
        end
        if (fb_addr == 19'd2) hs2_cyc = cyc;
      end
      if (stall_on && fb_we && fb_addr == 19'd2) begin
        we2_cycles++;
        if (we2_cycles == 1) we2_data = fb_data;
        else chk("stall_data_stable", 32'(fb_data), 32'(we2_data));
      end
      if (enable) begin
        n_en++;
        chk("en_in_window", {30'd0, x_dest < 10'(w_cur), y_dest < 10'(h_cur)}, 32'd3);
        if (stall_on && hs2_cyc >= 0 && en_after < 0) en_after = cyc;
      end
      if (done) n_done++;
      if (erro) n_erro++;
    end
  end

  task automatic push_frame(input int w, input int h);
    int sx, sy;
    logic [7:0] d;
`ifdef VARREDURA_BORDA_EN
    sx = LFB;
    sy = AFB;
`else
    sx = w;
    sy = h;
`endif
    for (int y = 0; y < sy; y++) begin
      for (int x = 0; x < sx; x++) begin
        d = (x < w && y < h) ? pix(10'(x), 10'(y)) : 8'h00;
        exp_q.push_back({19'(y * LFB + x), d});
      end
    end
  endtask

  task automatic window(input logic [2:0] esc, output int w, output int h);
    w = LO * int'(esc);
    h = AO * int'(esc);
    if (w > LFB) w = LFB;
    if (h > AFB) h = AFB;
  endtask

  task automatic run_frame(input logic [2:0] esc, input int extra, input bit poke);
    int w, h, sx, sy, c0, wr0, en0, er0, lim;
    window(esc, w, h);
    w_cur = w;
    h_cur = h;
`ifdef VARREDURA_BORDA_EN
    sx = LFB;
    sy = AFB;
`else
    sx = w;
    sy = h;
`endif
    push_frame(w, h);
    wr0 = n_wr;
    en0 = n_en;
    er0 = n_erro;
    lim = 1 + w * h * P + (sx * sy - w * h) + extra;
    escala = esc;
    start  = 1'b1;
    c0     = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_enable", 32'(enable), 32'd1);
    chk("start_xy", {12'd0, x_dest, y_dest}, 32'd0);
    while (!done && (cyc - c0) < lim + 20) begin
      if (poke && (cyc - c0) == 10) begin
        start  = 1'b1;
        escala = 3'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_cycle", 32'(cyc - c0), 32'(lim));
    chk("done_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("write_count", 32'(n_wr - wr0), 32'(sx * sy));
    chk("enable_count", 32'(n_en - en0), 32'(w * h));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("last_addr", 32'(last_addr), 32'((sy - 1) * LFB + sx - 1));
    chk("no_erro_in_frame", 32'(n_erro - er0), 32'd0);
  endtask

  initial begin
    int w, h, wr0, d0, c0;
    rst    = 1'b1;
    start  = 1'b0;
    escala = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_xy", {12'd0, x_dest, y_dest}, 32'd0);
    chk("rst_addr", 32'(fb_addr), 32'd0);
    chk("rst_ctrl", {19'd0, enable, fb_data, fb_we, busy, done, erro}, 32'd0);

    // Simultaneous rst and start: reset wins.
    start  = 1'b1;
    escala = 3'd1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    chk("rst_beats_start", {30'd0, busy, enable}, 32'd0);
    @(negedge clk);

    // Zero scale: erro pulse only.
    escala = 3'd0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("erro_pulse", 32'(erro), 32'd1);
    chk("erro_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("erro_one_cycle", 32'(erro), 32'd0);
    chk("erro_no_enable", {30'd0, busy, enable}, 32'd0);
    chk("erro_no_writes", 32'(n_wr), 32'd0);

    run_frame(3'd1, 0, 1'b0);
    run_frame(3'd3, 0, 1'b1);
    run_frame(3'd2, 0, 1'b0);

    // Stall on pixel (2,0).
    stall_on   = 1'b1;
    stall_left = 5;
    we2_cycles = 0;
    hs2_cyc    = -1;
    en_after   = -1;
    run_frame(3'd1, 5, 1'b0);
    chk("stall_we_cycles", 32'(we2_cycles), 32'd6);
    chk("stall_next_enable", 32'(en_after - hs2_cyc), 32'd1);
    stall_on = 1'b0;

    // Reset mid-frame after the 20th write.
    window(3'd2, w, h);
    w_cur = w;
    h_cur = h;
    push_frame(w, h);
    wr0    = n_wr;
    d0     = n_done;
    escala = 3'd2;
    start  = 1'b1;
    c0     = cyc;
    @(negedge clk);
    start = 1'b0;
    while ((n_wr - wr0) < 20 && (cyc - c0) < 2000) @(negedge clk);
    chk("abort_reached", 32'(n_wr - wr0 >= 20), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_xy", {12'd0, x_dest, y_dest}, 32'd0);
    chk("abort_addr", 32'(fb_addr), 32'd0);
    chk("abort_ctrl", {19'd0, enable, fb_data, fb_we, busy, done, erro}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    run_frame(3'd2, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/varredura_destino.md
# varredura_destino

Raster-scan controller directly upstream of the nearest-neighbour scaler. On `start` it walks destination coordinates (`x_dest`, `y_dest`) across the scaled window, one pixel at a time. For each pixel it pulses `enable` to the scaler, waits for the scaled pixel to return, and writes it to the output framebuffer under a `fb_we`/`fb_ready` handshake. It owns frame sequencing, clipping and completion signalling.

## Interface
- `LARGURA_ORIG`, 320: source image width in pixels.
- `ALTURA_ORIG`, 240: source image height in pixels.
- `LARGURA_FB`, 640: framebuffer width in pixels.
- `ALTURA_FB`, 480: framebuffer height in pixels.
- `LAT_ROM`, 2: cycles from the coordinate/`enable` cycle to valid `pixel_in`. Covers the ROM read plus the scaler output register. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to scan a frame; ignored while `busy`.
- `escala`  in  3  scale factor, sampled only on an accepted `start`.
- `pixel_in`  in  8  scaled pixel returned by the scaler.
- `fb_ready`  in  1  framebuffer accepts the write this cycle.
- `x_dest`  out  10  destination column presented to the scaler.
- `y_dest`  out  10  destination row presented to the scaler.
- `enable`  out  1  one-cycle strobe: scaler samples this pixel.
- `fb_addr`  out  19  equals `y_dest*LARGURA_FB + x_dest`.
- `fb_data`  out  8  pixel being written.
- `fb_we`  out  1  write request; held until handshake.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at frame completion.
- `erro`  out  1  one-cycle pulse when `start` carries `escala==0`.

## Operation
- FSM states: `IDLE`, `EMITE`, `ESPERA`, `ESCREVE`, `FIM`.
- **`IDLE`**
  - On `start` with `escala!=0`: latch `escala`, compute the window, zero the coordinates, go to `EMITE`.
  - On `start` with `escala==0`: pulse `erro`, stay in `IDLE`.
- **Window size (13-bit arithmetic)**
  - `W = min(LARGURA_ORIG*escala, LARGURA_FB)`.
  - `H = min(ALTURA_ORIG*escala, ALTURA_FB)`.
  - Anything beyond the framebuffer is clipped and never emitted.
- **`EMITE`**: `enable=1` for one cycle with the current coordinates, then `ESPERA`.
- **`ESPERA`**
  - A 4-bit counter counts `LAT_ROM-1` additional cycles.
  - In the last of those cycles, `pixel_in` is captured into `fb_data`; go to `ESCREVE`.
- **`ESCREVE`**
  - `fb_we=1` with stable `fb_addr`/`fb_data` until `fb_we && fb_ready`.
  - On that handshake cycle the coordinates advance: `x+1`; at `x==W-1` go to `x=0`, `y+1`.
  - If the last pixel `(W-1,H-1)` was written, go to `FIM`; otherwise go to `EMITE`.
- **`FIM`**: `done=1` for one cycle, `busy` drops, return to `IDLE`.
- `start` during `busy` is ignored; there is no queuing.
- `x_dest`/`y_dest` hold their value between `enable` strobes.
- `fb_addr` is registered and updates together with the coordinates.

## Timing
- **Reset values** (after `rst` high on any edge): all outputs 0, state `IDLE`.
- **Reset mid-frame**
  - Aborts immediately; no `done` pulse.
  - An in-flight `fb_we` drops in the next cycle.
- **Start latency**: `start` accepted at cycle 0; `busy` and the first `enable` at cycle 1.
- **Per-pixel throughput**: `LAT_ROM+2` cycles with `fb_ready` held high. Each stalled cycle adds one.
- **Frame length**: with no stalls, `done` asserts at cycle `1 + W*H*(LAT_ROM+2)`.
- **`fb_ready`** is ignored whenever `fb_we=0`.
- **Simultaneous `rst` and `start`**: reset wins.

## Configuration
- **Macro `VARREDURA_BORDA_EN`**
  - **Defined**:
    - The scan covers the full `LARGURA_FB x ALTURA_FB` framebuffer.
    - Pixels inside the window behave as above.
    - Pixels outside the window skip `EMITE`/`ESPERA`: no `enable`, and `fb_data=8'h00` is written directly.
    - These border writes take 1 cycle each when `fb_ready` is high.
    - `done` follows the write to `(LARGURA_FB-1, ALTURA_FB-1)`.
  - **Undefined**: only the `W x H` window is written; the rest of the framebuffer is untouched.

## Test plan
- `escala=1`, `fb_ready=1`, `LAT_ROM=2`, macro undefined -> expected response:
  - exactly 76800 writes, first `fb_addr=0`, last `fb_addr=153279`;
  - `done` at cycle 307201;
  - `fb_data` equals the stub `pixel_in` returned for each coordinate.
- `escala=3` -> window clipped to 640x480: 307200 writes, last `fb_addr=307199`, no coordinate ≥ 640/480.
- `escala=0` on `start` -> `erro` for one cycle, `busy` stays 0, zero writes.
- `fb_ready` low for 5 cycles on pixel (2,0) -> `fb_we` held with `fb_addr=2` and stable `fb_data` for 6 cycles; the next `enable` comes one cycle after the handshake.
- `rst` asserted at the 1000th write, then `start` again -> outputs 0 the cycle after `rst`, no `done`; the new frame restarts at `fb_addr=0`.
- Macro defined, `escala=1` -> 307200 writes, 76800 `enable` strobes, address 320 written with `8'h00`.
